// File: rtl/btn_repeat_ctrl.sv
// Button gesture controller: tap, hold-to-auto-repeat and two-button chord clear for a 6-bit
// counter. Define BTN_SAT_EN to saturate the counter at 0/63 instead of wrapping.
module btn_repeat_ctrl #(
  parameter int unsigned CLK_HZ   = 27_000_000,
  parameter int unsigned CHORD_MS = 50,
  parameter int unsigned HOLD_MS  = 500,
  parameter int unsigned RATE_MS  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b1_lv,
  input  logic       b2_lv,
  output logic [5:0] cnt,
  output logic       step_up,
  output logic       step_dn,
  output logic       chord,
  output logic       busy
);

  localparam int unsigned CHORD_LIM = (CLK_HZ / 1000) * CHORD_MS;
  localparam int unsigned HOLD_LIM  = (CLK_HZ / 1000) * HOLD_MS;
  localparam int unsigned RATE_LIM  = (CLK_HZ / 1000) * RATE_MS;
  localparam int unsigned MAX_LIM   = (CHORD_LIM > HOLD_LIM) ?
                                      ((CHORD_LIM > RATE_LIM) ? CHORD_LIM : RATE_LIM) :
                                      ((HOLD_LIM > RATE_LIM) ? HOLD_LIM : RATE_LIM);
  localparam int unsigned TW        = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;

  localparam logic [TW-1:0] CHORD_END = TW'(CHORD_LIM - 1);
  localparam logic [TW-1:0] HOLD_END  = TW'(HOLD_LIM - 1);
  localparam logic [TW-1:0] RATE_END  = TW'(RATE_LIM - 1);

  typedef enum logic [2:0] {StIdle, StArm, StHold, StRepeat, StChord} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_q, dir_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          up_q, up_d, dn_q, dn_d, chord_q, chord_d;
  logic          do_step, do_chord;
  logic          own, other;

  // dir_q selects which button owns the gesture (1 = b1 / up).
  assign own   = dir_q ? b1_lv : b2_lv;
  assign other = dir_q ? b2_lv : b1_lv;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    dir_d    = dir_q;
    do_step  = 1'b0;
    do_chord = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (b1_lv && b2_lv) begin
          state_d  = StChord;
          do_chord = 1'b1;
        end else if (b1_lv || b2_lv) begin
          state_d = StArm;
          dir_d   = b1_lv;
          timer_d = '0;
        end
      end
      StArm: begin
        if (other) begin
          state_d  = StChord;
          do_chord = 1'b1;
        end else if (!own) begin
          state_d = StIdle;
          do_step = 1'b1;
        end else if (timer_q == CHORD_END) begin
          state_d = StHold;
          timer_d = '0;
          do_step = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StHold: begin
        if (!own) begin
          state_d = StIdle;
        end else if (timer_q == HOLD_END) begin
          state_d = StRepeat;
          timer_d = '0;
          do_step = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StRepeat: begin
        if (!own) begin
          state_d = StIdle;
        end else if (timer_q == RATE_END) begin
          timer_d = '0;
          do_step = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StChord: begin
        if (!b1_lv && !b2_lv) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter and pulses are registered so every decision shows up exactly one cycle later.
  always_comb begin
    cnt_d   = cnt_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    chord_d = 1'b0;
    if (do_chord) begin
      cnt_d   = '0;
      chord_d = 1'b1;
    end else if (do_step) begin
`ifdef BTN_SAT_EN
      if (dir_q && cnt_q != 6'd63) begin
        cnt_d = cnt_q + 6'd1;
        up_d  = 1'b1;
      end else if (!dir_q && cnt_q != 6'd0) begin
        cnt_d = cnt_q - 6'd1;
        dn_d  = 1'b1;
      end
`else
      if (dir_q) begin
        cnt_d = cnt_q + 6'd1;
        up_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - 6'd1;
        dn_d  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      chord_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      chord_q <= chord_d;
    end
  end

  assign cnt     = cnt_q;
  assign step_up = up_q;
  assign step_dn = dn_q;
  assign chord   = chord_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_btn_repeat_ctrl.sv
// Self-checking bench for btn_repeat_ctrl: per-cycle expectations are queued as inputs are
// driven and compared after the following clock edge.
module tb_btn_repeat_ctrl;

  localparam int DecNone  = 0;
  localparam int DecUp    = 1;
  localparam int DecDn    = 2;
  localparam int DecChord = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       b1_lv, b2_lv;
  logic [5:0] cnt;
  logic       step_up, step_dn, chord, busy;

  typedef struct {
    logic [5:0] cnt;
    logic       up;
    logic       dn;
    logic       ch;
    int         busy;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] mcnt;
  int         checks = 0;
  int         errors = 0;

  btn_repeat_ctrl #(
    .CLK_HZ  (1000),
    .CHORD_MS(4),
    .HOLD_MS (10),
    .RATE_MS (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .b1_lv  (b1_lv),
    .b2_lv  (b2_lv),
    .cnt    (cnt),
    .step_up(step_up),
    .step_dn(step_dn),
    .chord  (chord),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply_reset(input logic b1, input logic b2);
    rst   = 1'b1;
    b1_lv = b1;
    b2_lv = b2;
    @(posedge clk);
    #1;
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_up", int'(step_up), 0);
    chk("rst_dn", int'(step_dn), 0);
    chk("rst_chord", int'(chord), 0);
    chk("rst_busy", int'(busy), 0);
    rst  = 1'b0;
    mcnt = 6'd0;
    sb.delete();
  endtask

  // Drive one cycle of inputs, queue what the next cycle must show, then compare.
  task automatic drive(input string tag, input logic b1, input logic b2, input int dec,
                       input int ebusy);
    exp_t e;
    b1_lv = b1;
    b2_lv = b2;
    e.up  = 1'b0;
    e.dn  = 1'b0;
    e.ch  = 1'b0;
    if (dec == DecChord) begin
      mcnt = 6'd0;
      e.ch = 1'b1;
    end else if (dec == DecUp) begin
`ifdef BTN_SAT_EN
      if (mcnt != 6'd63) begin
        mcnt = mcnt + 6'd1;
        e.up = 1'b1;
      end
`else
      mcnt = mcnt + 6'd1;
      e.up = 1'b1;
`endif
    end else if (dec == DecDn) begin
`ifdef BTN_SAT_EN
      if (mcnt != 6'd0) begin
        mcnt = mcnt - 6'd1;
        e.dn = 1'b1;
      end
`else
      mcnt = mcnt - 6'd1;
      e.dn = 1'b1;
`endif
    end
    e.cnt  = mcnt;
    e.busy = ebusy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_cnt"}, int'(cnt), int'(e.cnt));
    chk({tag, "_up"}, int'(step_up), int'(e.up));
    chk({tag, "_dn"}, int'(step_dn), int'(e.dn));
    chk({tag, "_chord"}, int'(chord), int'(e.ch));
    if (e.busy >= 0) chk({tag, "_busy"}, int'(busy), e.busy);
  endtask

  task automatic tap(input string tag, input logic up);
    drive(tag, up, !up, DecNone, 1);
    drive(tag, up, !up, DecNone, 1);
    drive(tag, 1'b0, 1'b0, up ? DecUp : DecDn, 0);
    drive(tag, 1'b0, 1'b0, DecNone, 0);
  endtask

  // Held-button schedule: first step at cycle 4, then 14, then every 5 cycles.
  function automatic bit is_step(input int i);
    return (i == 4) || (i >= 14 && ((i - 14) % 5) == 0);
  endfunction

  initial begin
    rst   = 1'b1;
    b1_lv = 1'b0;
    b2_lv = 1'b0;
    mcnt  = 6'd0;
    apply_reset(1'b0, 1'b0);

    tap("tap", 1'b1);

    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive("rep", 1'b1, 1'b0, is_step(i) ? DecUp : DecNone, 1);
    drive("rep_rel", 1'b0, 1'b0, DecNone, 0);
    drive("rep_end", 1'b0, 1'b0, DecNone, 0);
    chk("rep_total", int'(cnt), 7);

    apply_reset(1'b0, 1'b0);
    tap("wrap", 1'b0);

    apply_reset(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tap("pre", 1'b1);
    chk("pre_cnt", int'(cnt), 5);
    drive("chd", 1'b1, 1'b0, DecNone, 1);
    drive("chd", 1'b1, 1'b0, DecNone, 1);
    drive("chd_hit", 1'b1, 1'b1, DecChord, 1);
    for (int i = 0; i < 3; i++) drive("chd_both", 1'b1, 1'b1, DecNone, 1);
    for (int i = 0; i < 6; i++) drive("chd_b1", 1'b1, 1'b0, DecNone, 1);
    drive("chd_rel", 1'b0, 1'b0, DecNone, 0);
    drive("chd_idle", 1'b0, 1'b0, DecNone, 0);

    drive("chd_idle2", 1'b1, 1'b1, DecChord, 1);
    drive("chd_idle2_rel", 1'b0, 1'b0, DecNone, 0);

    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      drive("lock", 1'b1, (i >= 20 && i < 40), is_step(i) ? DecUp : DecNone, 1);
    end
    drive("lock_rel", 1'b0, 1'b0, DecNone, 0);
    chk("lock_total", int'(cnt), 11);

    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 21; i++) drive("mid", 1'b1, 1'b0, is_step(i) ? DecUp : DecNone, 1);
    apply_reset(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive("post", 1'b1, 1'b0, (i == 4) ? DecUp : DecNone, 1);
    drive("post_rel", 1'b0, 1'b0, DecNone, 0);
    chk("post_total", int'(cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
